// File: rtl/matrix_c_uart_dump.sv
// Result-BRAM read-back: walks addresses 0..NUM_WORDS-1 and ships each 32-bit
// word over an 8N1 UART line, least-significant byte first.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line idle high, waiting for start
// RD_REQ    | one-cycle BRAM read strobe at the current word address
// RD_WAIT   | BRAM_LATENCY cycles until bram_dout is valid, then capture it
// LOAD      | pick the current byte of the held word into the shift register
// TX_START  | start bit (low) for CLKS_PER_BIT cycles
// TX_DATA   | eight data bits, LSB first, CLKS_PER_BIT cycles each
// TX_STOP   | stop bit (high); next byte or next word
// NEXT      | advance word index or finish
// DONE      | one-cycle done pulse, busy drops, address returns to 0
module matrix_c_uart_dump #(
   parameter int NUM_WORDS    = 16,
   parameter int ADDR_W       = 4,
   parameter int BRAM_LATENCY = 2,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [31:0]       bram_dout,
   output logic              uart_tx,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        LAT_LAST  = 3'(BRAM_LATENCY - 1);
   localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(NUM_WORDS - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_LOAD,
      S_TX_START,
      S_TX_DATA,
      S_TX_STOP,
      S_NEXT,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  clk_cnt;
   logic [2:0]        lat_cnt;
   logic [2:0]        bit_idx;
   logic [1:0]        byte_idx;
   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       holding;
   logic [7:0]        shift;
   logic              in_frame;
   logic              bit_end;
   logic              lat_end;

   assign in_frame = (state == S_TX_START) || (state == S_TX_DATA) || (state == S_TX_STOP);
   assign bit_end  = in_frame && (clk_cnt == BIT_LAST);
   assign lat_end  = (state == S_RD_WAIT) && (lat_cnt == LAT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start) state_nxt = S_RD_REQ;
         S_RD_REQ:   state_nxt = S_RD_WAIT;
         S_RD_WAIT:  if (lat_end) state_nxt = S_LOAD;
         S_LOAD:     state_nxt = S_TX_START;
         S_TX_START: if (bit_end) state_nxt = S_TX_DATA;
         S_TX_DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = S_TX_STOP;
         S_TX_STOP:  if (bit_end) state_nxt = (byte_idx == 2'd3) ? S_NEXT : S_LOAD;
         S_NEXT:     state_nxt = (word_idx == WORD_LAST) ? S_DONE : S_RD_REQ;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_cnt  <= '0;
         lat_cnt  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         word_idx <= '0;
         holding  <= '0;
         shift    <= '0;
      end else begin
         // Bit timer restarts at every bit boundary so frames never drift.
         if (in_frame) begin
            clk_cnt <= bit_end ? '0 : clk_cnt + CNT_W'(1);
         end else begin
            clk_cnt <= '0;
         end

         if (state == S_RD_WAIT) begin
            lat_cnt <= lat_cnt + 3'd1;
         end else begin
            lat_cnt <= '0;
         end

         if (lat_end) begin
            holding  <= bram_dout;
            byte_idx <= '0;
         end else if ((state == S_TX_STOP) && bit_end && (byte_idx != 2'd3)) begin
            byte_idx <= byte_idx + 2'd1;
         end

         if (state == S_LOAD) begin
            shift <= holding[{byte_idx, 3'b000} +: 8];
         end else if ((state == S_TX_DATA) && bit_end) begin
            shift <= {1'b0, shift[7:1]};
         end

         if (state == S_TX_DATA) begin
            if (bit_end) bit_idx <= bit_idx + 3'd1;
         end else begin
            bit_idx <= '0;
         end

         // Word index doubles as the BRAM address and parks at 0 once done.
         if ((state == S_IDLE) && start) begin
            word_idx <= '0;
         end else if (state == S_NEXT) begin
            word_idx <= (word_idx == WORD_LAST) ? '0 : word_idx + ADDR_W'(1);
         end
      end
   end

   assign bram_en   = (state == S_RD_REQ);
   assign bram_addr = word_idx;
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign done      = (state == S_DONE);

   always_comb begin
      uart_tx = 1'b1;
      if (state == S_TX_START) begin
         uart_tx = 1'b0;
      end else if (state == S_TX_DATA) begin
         uart_tx = shift[0];
      end
   end

endmodule

// File: tb/tb_matrix_c_uart_dump.sv
// Bench for matrix_c_uart_dump: three instances (BRAM latency 2, 1, 4) share
// start/reset and a word table; each has its own BRAM model and UART decoder.
module tb_matrix_c_uart_dump;

   localparam int CPB = 4;
   localparam int NW  = 4;
   localparam int AW  = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic [31:0] mem [NW];

   logic          en_s   [3];
   logic [AW-1:0] addr_s [3];
   logic          tx_s   [3];
   logic          busy_s [3];
   logic          done_s [3];

   int checks = 0;
   int failures = 0;
   int b_rx [3];
   int b_rd [3];
   int b_done [3];
   int b_err [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      logic [31:0] pipe [L];
      logic [7:0] rx [0:127];
      logic [AW-1:0] rd_addr [0:63];
      logic [7:0] rb;
      int rx_cnt = 0;
      int rd_cnt = 0;
      int done_cnt = 0;
      int bus_err = 0;
      int uart_err = 0;
      logic en_prev = 1'b0;
      logic done_prev = 1'b0;

      matrix_c_uart_dump #(
         .NUM_WORDS(NW), .ADDR_W(AW), .BRAM_LATENCY(L), .CLKS_PER_BIT(CPB)
      ) u_dut (
         .clk(clk), .reset(reset), .start(start),
         .bram_en(en_s[g]), .bram_addr(addr_s[g]), .bram_dout(pipe[L-1]),
         .uart_tx(tx_s[g]), .busy(busy_s[g]), .done(done_s[g])
      );

      // BRAM of latency L; unread cycles yield X so a mistimed capture shows up.
      always @(posedge clk) begin
         pipe[0] <= en_s[g] ? mem[addr_s[g]] : 32'hx;
         for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
      end

      always @(negedge clk) begin
         if (en_s[g] === 1'b1) begin
            if (rd_cnt < 64) rd_addr[rd_cnt] = addr_s[g];
            rd_cnt++;
            if (en_prev === 1'b1) bus_err++;
         end
         if (done_s[g] === 1'b1) begin
            done_cnt++;
            if (done_prev === 1'b1 || busy_s[g] !== 1'b0) bus_err++;
         end
         en_prev = en_s[g];
         done_prev = done_s[g];
      end

      always begin
         @(negedge clk);
         if (reset === 1'b1 && tx_s[g] === 1'b0) begin
            repeat (CPB/2) @(negedge clk);
            if (tx_s[g] !== 1'b0) uart_err++;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               rb[i] = tx_s[g];
            end
            repeat (CPB) @(negedge clk);
            if (tx_s[g] !== 1'b1) uart_err++;
            if (rx_cnt < 128) rx[rx_cnt] = rb;
            rx_cnt++;
         end
      end
   end

   function automatic int n_rx(input int i);
      case (i)
         0: n_rx = g_dut[0].rx_cnt;
         1: n_rx = g_dut[1].rx_cnt;
         default: n_rx = g_dut[2].rx_cnt;
      endcase
   endfunction

   function automatic logic [7:0] rx_byte(input int i, input int k);
      rx_byte = 8'hxx;
      if (k >= 0 && k < 128) begin
         case (i)
            0: rx_byte = g_dut[0].rx[k];
            1: rx_byte = g_dut[1].rx[k];
            default: rx_byte = g_dut[2].rx[k];
         endcase
      end
   endfunction

   function automatic int n_rd(input int i);
      case (i)
         0: n_rd = g_dut[0].rd_cnt;
         1: n_rd = g_dut[1].rd_cnt;
         default: n_rd = g_dut[2].rd_cnt;
      endcase
   endfunction

   function automatic logic [AW-1:0] rd_at(input int i, input int k);
      rd_at = 'x;
      if (k >= 0 && k < 64) begin
         case (i)
            0: rd_at = g_dut[0].rd_addr[k];
            1: rd_at = g_dut[1].rd_addr[k];
            default: rd_at = g_dut[2].rd_addr[k];
         endcase
      end
   endfunction

   function automatic int n_done(input int i);
      case (i)
         0: n_done = g_dut[0].done_cnt;
         1: n_done = g_dut[1].done_cnt;
         default: n_done = g_dut[2].done_cnt;
      endcase
   endfunction

   function automatic int n_err(input int i);
      case (i)
         0: n_err = g_dut[0].bus_err + g_dut[0].uart_err;
         1: n_err = g_dut[1].bus_err + g_dut[1].uart_err;
         default: n_err = g_dut[2].bus_err + g_dut[2].uart_err;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic take_snap();
      for (int i = 0; i < 3; i++) begin
         b_rx[i] = n_rx(i);
         b_rd[i] = n_rd(i);
         b_done[i] = n_done(i);
         b_err[i] = n_err(i);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done_all(input string tag);
      int left = 4000;
      while (left > 0 && !(n_done(0) > b_done[0] && n_done(1) > b_done[1] &&
                           n_done(2) > b_done[2])) begin
         @(negedge clk);
         left--;
      end
      chk(tag, left > 0, 1'b1);
      repeat (30) @(negedge clk);
   endtask

   // Reference: every word, bytes little-endian, addresses 0..NW-1 once each.
   task automatic check_dump(input int i, input string tag);
      logic [31:0] w;
      int nb;
      nb = n_rx(i) - b_rx[i];
      chk($sformatf("%s_i%0d_nbytes", tag, i), nb, 4 * NW);
      for (int k = 0; k < NW; k++) begin
         w = '0;
         for (int b = 0; b < 4; b++)
            w = w | (32'(rx_byte(i, b_rx[i] + 4*k + b)) << (8*b));
         chk($sformatf("%s_i%0d_word%0d", tag, i, k), w, mem[k]);
      end
      chk($sformatf("%s_i%0d_nreads", tag, i), n_rd(i) - b_rd[i], NW);
      for (int k = 0; k < NW; k++)
         chk($sformatf("%s_i%0d_addr%0d", tag, i, k), rd_at(i, b_rd[i] + k), k);
      chk($sformatf("%s_i%0d_ndone", tag, i), n_done(i) - b_done[i], 1);
      chk($sformatf("%s_i%0d_proto", tag, i), n_err(i) - b_err[i], 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int left;
      int rd0;
      logic expv;
      for (int k = 0; k < NW; k++) mem[k] = $urandom;

      repeat (3) @(negedge clk);
      chk("rst_tx", tx_s[0], 1'b1);
      chk("rst_busy", busy_s[0], 1'b0);
      chk("rst_done", done_s[0], 1'b0);
      chk("rst_en", en_s[0], 1'b0);
      chk("rst_addr", addr_s[0], 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Frame timing on a 0x55 byte, latency-2 instance.
      mem[0] = 32'h0000_0055;
      take_snap();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("acc_busy", busy_s[0], 1'b1);
      chk("acc_en", en_s[0], 1'b1);
      chk("acc_addr", addr_s[0], 0);
      @(negedge clk);
      chk("en_one_cycle", en_s[0], 1'b0);
      repeat (2) @(negedge clk);
      chk("pre_frame_idle", tx_s[0], 1'b1);
      @(negedge clk);
      chk("start_bit_edge", tx_s[0], 1'b0);
      bad = 0;
      for (int c = 1; c < 40; c++) begin
         @(negedge clk);
         if (c < 4) expv = 1'b0;
         else if (c < 36) expv = (((32'h55 >> ((c - 4) / 4)) & 1) != 0);
         else expv = 1'b1;
         if (tx_s[0] !== expv) bad++;
      end
      chk("frame_55_bits", bad, 0);
      @(negedge clk);
      chk("load_gap_high", tx_s[0], 1'b1);
      @(negedge clk);
      chk("next_start_bit", tx_s[0], 1'b0);
      wait_done_all("frame_timeout");
      for (int i = 0; i < 3; i++) check_dump(i, "frame");

      // Fixed table with a second start while busy in word 1.
      mem[0] = 32'h0403_0201;
      mem[1] = 32'hDEAD_BEEF;
      mem[2] = 32'h0000_0000;
      mem[3] = 32'hFFFF_FFFF;
      take_snap();
      pulse_start();
      left = 2000;
      while (left > 0 && addr_s[0] !== 2'd1) begin
         @(negedge clk);
         left--;
      end
      chk("reach_word1", left > 0, 1'b1);
      repeat (30) @(negedge clk);
      pulse_start();
      wait_done_all("table_timeout");
      for (int i = 0; i < 3; i++) check_dump(i, "table");
      chk("idle_addr_zero", addr_s[0], 0);

      take_snap();
      pulse_start();
      wait_done_all("again_timeout");
      for (int i = 0; i < 3; i++) check_dump(i, "again");

      for (int k = 0; k < NW; k++) mem[k] = $urandom;
      take_snap();
      pulse_start();
      wait_done_all("rand_timeout");
      for (int i = 0; i < 3; i++) check_dump(i, "rand");

      // Asynchronous reset in the data bits of byte 2.
      take_snap();
      pulse_start();
      left = 3000;
      while (left > 0 && n_rx(0) < b_rx[0] + 2) begin
         @(negedge clk);
         left--;
      end
      while (left > 0 && tx_s[0] !== 1'b0) begin
         @(negedge clk);
         left--;
      end
      chk("reach_byte2", left > 0, 1'b1);
      repeat (CPB + 6) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_tx", tx_s[0], 1'b1);
      chk("arst_busy", busy_s[0], 1'b0);
      chk("arst_en", en_s[0], 1'b0);
      chk("arst_addr", addr_s[0], 0);
      chk("arst_tx_l1", tx_s[1], 1'b1);
      chk("arst_tx_l4", tx_s[2], 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      rd0 = n_rd(0);
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0 || en_s[i] !== 1'b0) bad++;
      end
      chk("idle_after_reset", bad, 0);
      chk("no_read_after_reset", n_rd(0) - rd0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
